// File: rtl/afu_pkg.sv
// Shared types and constants for the complex-multiply AFU.
// Job sequencer states, cache-line geometry and the datapath sample type.
package afu_pkg;

    typedef enum logic [1:0] {
        ST_IDLE,
        ST_RUN,
        ST_DRAIN,
        ST_FIN
    } job_state_t;

    localparam int CL_BYTES = 64;

    typedef struct packed {
        logic signed [15:0] re;
        logic signed [15:0] im;
    } complex_t;

endpackage

// File: rtl/credit_counter.sv
// Up/down credit counter saturating at [0, MAX]; load restores MAX.
// Updates one cycle after inc/dec; simultaneous inc and dec leave the count unchanged.
// No backpressure: the caller must gate dec on count != 0.
module credit_counter #(
    parameter int MAX = 4,
    parameter int CW  = $clog2(MAX + 1)
) (
    input  logic          clk,
    input  logic          rst_n,
    input  logic          load,
    input  logic          inc,
    input  logic          dec,
    output logic [CW-1:0] count
);

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            count <= CW'(MAX);
        end else if (load) begin
            count <= CW'(MAX);
        end else if (inc && !dec && count != CW'(MAX)) begin
            count <= count + CW'(1);
        end else if (dec && !inc && count != '0) begin
            count <= count - CW'(1);
        end
    end

endmodule

// File: rtl/afu_job_ctrl.sv
// Job sequencer: streams ctx_length line reads from src, line writes to dst as results pop out.
// Reads start the cycle after an accepted start; done pulses the cycle after the last write.
// Lines in flight are capped by MAX_CREDITS; requests hold valid and address until accepted.
module afu_job_ctrl #(
    parameter int ADDR_WIDTH  = 32,
    parameter int MAX_CREDITS = 4,
    parameter int CL_BYTES    = afu_pkg::CL_BYTES
) (
    input  logic                  clk,
    input  logic                  reset,
    input  logic                  start,
    input  logic [31:0]           ctx_length,
    input  logic [ADDR_WIDTH-1:0] src_addr,
    input  logic [ADDR_WIDTH-1:0] dst_addr,
    output logic                  rd_req_valid,
    input  logic                  rd_req_ready,
    output logic [ADDR_WIDTH-1:0] rd_req_addr,
    output logic                  wr_req_valid,
    input  logic                  wr_req_ready,
    output logic [ADDR_WIDTH-1:0] wr_req_addr,
    input  logic                  output_fifo_empty,
    output logic                  output_fifo_re,
    output logic                  busy,
    output logic                  done
);

    import afu_pkg::*;

    localparam int CW = $clog2(MAX_CREDITS + 1);

    job_state_t    state;
    logic [31:0]   len;
    logic [31:0]   rd_cnt;
    logic [31:0]   wr_cnt;
    logic [CW-1:0] credits;
    logic          start_acc;
    logic          rd_hs;
    logic          wr_hs;

    assign start_acc      = start && (state == ST_IDLE);
    assign rd_req_valid   = (state == ST_RUN) && (credits != '0);
    assign wr_req_valid   = ((state == ST_RUN) || (state == ST_DRAIN)) &&
                            !output_fifo_empty && (wr_cnt < len);
    assign rd_hs          = rd_req_valid && rd_req_ready;
    assign wr_hs          = wr_req_valid && wr_req_ready;
    assign output_fifo_re = wr_hs;
    assign busy           = (state == ST_RUN) || (state == ST_DRAIN);
    assign done           = (state == ST_FIN);

    credit_counter #(
        .MAX (MAX_CREDITS),
        .CW  (CW)
    ) u_credits (
        .clk   (clk),
        .rst_n (reset),
        .load  (start_acc),
        .inc   (wr_hs),
        .dec   (rd_hs),
        .count (credits)
    );

    // Addresses advance by one line per handshake rather than multiplying the counters.
    always_ff @(posedge clk or negedge reset) begin
        if (!reset) begin
            state       <= ST_IDLE;
            len         <= '0;
            rd_cnt      <= '0;
            wr_cnt      <= '0;
            rd_req_addr <= '0;
            wr_req_addr <= '0;
        end else begin
            case (state)
                ST_IDLE: begin
                    if (start) begin
                        len         <= ctx_length;
                        rd_cnt      <= '0;
                        wr_cnt      <= '0;
                        rd_req_addr <= src_addr;
                        wr_req_addr <= dst_addr;
                        state       <= (ctx_length == 32'd0) ? ST_FIN : ST_RUN;
                    end
                end
                ST_RUN: begin
                    if (rd_hs && (rd_cnt + 32'd1 == len)) state <= ST_DRAIN;
                end
                ST_DRAIN: begin
                    if (wr_hs && (wr_cnt + 32'd1 == len)) state <= ST_FIN;
                end
                ST_FIN: begin
                    state <= ST_IDLE;
                end
            endcase
            if (rd_hs) begin
                rd_cnt      <= rd_cnt + 32'd1;
                rd_req_addr <= rd_req_addr + ADDR_WIDTH'(CL_BYTES);
            end
            if (wr_hs) begin
                wr_cnt      <= wr_cnt + 32'd1;
                wr_req_addr <= wr_req_addr + ADDR_WIDTH'(CL_BYTES);
            end
        end
    end

endmodule

// File: tb/tb_afu_job_ctrl.sv
// Directed bench for afu_job_ctrl with a delayed-FIFO host model and address scoreboards.
module tb_afu_job_ctrl;

    localparam int AW   = 32;
    localparam int MAXC = 4;
    localparam int CLB  = 64;

    logic          clk = 1'b0;
    logic          reset;
    logic          start;
    logic [31:0]   ctx_length;
    logic [AW-1:0] src_addr;
    logic [AW-1:0] dst_addr;
    logic          rd_req_valid;
    logic          rd_req_ready;
    logic [AW-1:0] rd_req_addr;
    logic          wr_req_valid;
    logic          wr_req_ready;
    logic [AW-1:0] wr_req_addr;
    logic          output_fifo_empty;
    logic          output_fifo_re;
    logic          busy;
    logic          done;

    afu_job_ctrl #(
        .ADDR_WIDTH  (AW),
        .MAX_CREDITS (MAXC),
        .CL_BYTES    (CLB)
    ) dut (
        .clk               (clk),
        .reset             (reset),
        .start             (start),
        .ctx_length        (ctx_length),
        .src_addr          (src_addr),
        .dst_addr          (dst_addr),
        .rd_req_valid      (rd_req_valid),
        .rd_req_ready      (rd_req_ready),
        .rd_req_addr       (rd_req_addr),
        .wr_req_valid      (wr_req_valid),
        .wr_req_ready      (wr_req_ready),
        .wr_req_addr       (wr_req_addr),
        .output_fifo_empty (output_fifo_empty),
        .output_fifo_re    (output_fifo_re),
        .busy              (busy),
        .done              (done)
    );

    always #5 clk = ~clk;

    int            checks   = 0;
    int            failures = 0;
    int            cyc      = 0;
    logic [AW-1:0] exp_rd_q[$];
    logic [AW-1:0] exp_wr_q[$];
    int            arr_q[$];
    int            fifo_cnt = 0;
    logic          fifo_block = 1'b0;
    logic          rdy_rand   = 1'b0;
    logic          mon_en     = 1'b0;
    logic          done_due   = 1'b0;
    int            tb_len   = 0;
    int            tb_rd    = 0;
    int            tb_wr    = 0;
    int            pops     = 0;
    int            done_cnt = 0;
    logic          rd_pend  = 1'b0;
    logic          wr_pend  = 1'b0;
    logic [AW-1:0] rd_hold  = '0;
    logic [AW-1:0] wr_hold  = '0;

    task automatic chk(input string tag, input logic [31:0] obs, input logic [31:0] exp);
        checks++;
        assert (obs === exp) else begin
            failures++;
            $error("FAIL %s observed=%0h expected=%0h", tag, obs, exp);
        end
    endtask

    task automatic step(input int n);
        repeat (n) @(posedge clk);
        #2;
    endtask

    // Host model: read data lands in the output FIFO two cycles after the read is accepted.
    initial begin
        rd_req_ready      = 1'b1;
        wr_req_ready      = 1'b1;
        output_fifo_empty = 1'b1;
        forever begin
            @(posedge clk);
            #1;
            cyc++;
            while (arr_q.size() > 0 && arr_q[0] <= cyc) begin
                fifo_cnt++;
                void'(arr_q.pop_front());
            end
            output_fifo_empty = (fifo_cnt == 0) || fifo_block;
            rd_req_ready      = rdy_rand ? 1'($urandom_range(0, 1)) : 1'b1;
            wr_req_ready      = rdy_rand ? 1'($urandom_range(0, 1)) : 1'b1;
        end
    end

    // Mid-cycle monitor: values seen here are the ones the next rising edge acts on.
    initial begin
        forever begin
            @(negedge clk);
            if (!reset) begin
                rd_pend = 1'b0;
                wr_pend = 1'b0;
            end else begin
                chk("rd_vld", 32'(rd_req_valid),
                    32'(mon_en && (tb_rd < tb_len) && ((tb_rd - tb_wr) < MAXC)));
                chk("wr_vld", 32'(wr_req_valid),
                    32'(mon_en && (tb_wr < tb_len) && !output_fifo_empty));
                chk("done", 32'(done), 32'(done_due));
                if (rd_pend) chk("rd_addr_hold", rd_req_addr, rd_hold);
                if (wr_pend) chk("wr_addr_hold", wr_req_addr, wr_hold);
                done_due = 1'b0;
                if (done === 1'b1) done_cnt++;
                if (output_fifo_re === 1'b1) pops++;
                if (rd_req_valid && rd_req_ready) begin
                    chk("rd_avail", 32'(exp_rd_q.size() > 0), 32'd1);
                    if (exp_rd_q.size() > 0) chk("rd_addr", rd_req_addr, exp_rd_q.pop_front());
                    arr_q.push_back(cyc + 2);
                    tb_rd++;
                end
                if (wr_req_valid && wr_req_ready) begin
                    chk("wr_avail", 32'(exp_wr_q.size() > 0), 32'd1);
                    if (exp_wr_q.size() > 0) chk("wr_addr", wr_req_addr, exp_wr_q.pop_front());
                    fifo_cnt--;
                    if (tb_wr + 1 == tb_len) done_due = 1'b1;
                    tb_wr++;
                end
                rd_pend = rd_req_valid && !rd_req_ready;
                wr_pend = wr_req_valid && !wr_req_ready;
                rd_hold = rd_req_addr;
                wr_hold = wr_req_addr;
            end
        end
    end

    task automatic launch(input int len, input logic [31:0] src, input logic [31:0] dst);
        mon_en = 1'b0;
        exp_rd_q.delete();
        exp_wr_q.delete();
        for (int i = 0; i < len; i++) begin
            exp_rd_q.push_back(src + 32'(i * CLB));
            exp_wr_q.push_back(dst + 32'(i * CLB));
        end
        tb_len     = len;
        tb_rd      = 0;
        tb_wr      = 0;
        pops       = 0;
        ctx_length = len;
        src_addr   = src;
        dst_addr   = dst;
        start      = 1'b1;
        step(1);
        start  = 1'b0;
        mon_en = 1'b1;
        if (len == 0) done_due = 1'b1;
        chk("busy_after_start", 32'(busy), 32'(len != 0));
    endtask

    task automatic wait_done(input int budget, input string tag);
        int d0;
        int n;
        d0 = done_cnt;
        n  = 0;
        while (done_cnt == d0 && n < budget) begin
            step(1);
            n++;
        end
        chk(tag, 32'(done_cnt != d0), 32'd1);
    endtask

    task automatic wait_rd(input int target, input int budget, input string tag);
        int n;
        n = 0;
        while (tb_rd < target && n < budget) begin
            step(1);
            n++;
        end
        chk(tag, 32'(tb_rd), 32'(target));
    endtask

    task automatic job_totals(input int len);
        chk("rd_total", 32'(tb_rd), 32'(len));
        chk("wr_total", 32'(tb_wr), 32'(len));
        chk("pop_total", 32'(pops), 32'(len));
        chk("rd_q_left", 32'(exp_rd_q.size()), 32'd0);
        chk("wr_q_left", 32'(exp_wr_q.size()), 32'd0);
        chk("busy_idle", 32'(busy), 32'd0);
    endtask

    task automatic reset_outputs(input string tag);
        chk({tag, "_rd_vld"}, 32'(rd_req_valid), 32'd0);
        chk({tag, "_wr_vld"}, 32'(wr_req_valid), 32'd0);
        chk({tag, "_fifo_re"}, 32'(output_fifo_re), 32'd0);
        chk({tag, "_busy"}, 32'(busy), 32'd0);
        chk({tag, "_done"}, 32'(done), 32'd0);
        chk({tag, "_rd_addr"}, rd_req_addr, 32'd0);
        chk({tag, "_wr_addr"}, wr_req_addr, 32'd0);
    endtask

    initial begin
        #500000;
        $display("FAIL watchdog expired at cycle %0d", cyc);
        $fatal(1, "watchdog");
    end

    initial begin
        reset      = 1'b0;
        start      = 1'b0;
        ctx_length = '0;
        src_addr   = '0;
        dst_addr   = '0;
        step(3);
        reset_outputs("por");
        reset = 1'b1;
        step(2);

        // Zero-length job completes without any request.
        launch(0, 32'h0000_0040, 32'h0000_0080);
        wait_done(5, "done_len0");
        step(3);
        job_totals(0);

        // Basic three-line job.
        launch(3, 32'h0000_1000, 32'h0000_8000);
        wait_done(100, "done_len3");
        step(2);
        job_totals(3);

        // Output FIFO held empty: reads stop at the credit limit.
        fifo_block = 1'b1;
        launch(10, 32'h0000_2000, 32'h0000_9000);
        step(12);
        chk("rd_capped", 32'(tb_rd), 32'(MAXC));
        chk("rd_vld_capped", 32'(rd_req_valid), 32'd0);
        fifo_block = 1'b0;
        wait_done(300, "done_len10");
        step(2);
        job_totals(10);

        // Random backpressure on both request channels.
        rdy_rand = 1'b1;
        launch(100, 32'h4000_0000, 32'h5000_0000);
        wait_done(5000, "done_len100");
        rdy_rand = 1'b0;
        step(2);
        job_totals(100);

        // Source address wraps past the top of the address space.
        launch(2, 32'hFFFF_FFC0, 32'h0000_0100);
        wait_done(100, "done_wrap");
        step(2);
        job_totals(2);

        // Reset in the middle of a job aborts it at once.
        launch(8, 32'h0000_6000, 32'h0000_7000);
        wait_rd(5, 100, "rd_before_reset");
        reset  = 1'b0;
        mon_en = 1'b0;
        exp_rd_q.delete();
        exp_wr_q.delete();
        arr_q.delete();
        fifo_cnt = 0;
        done_due = 1'b0;
        tb_len   = 0;
        tb_rd    = 0;
        tb_wr    = 0;
        #1;
        reset_outputs("midrst");
        step(2);
        reset = 1'b1;
        step(2);

        // A start while writes are still draining is ignored.
        launch(6, 32'h0000_A000, 32'h0000_B000);
        wait_rd(6, 100, "rd_before_drain");
        fifo_block = 1'b1;
        step(2);
        chk("drain_busy", 32'(busy), 32'd1);
        ctx_length = 32'd1;
        src_addr   = 32'hDEAD_0000;
        dst_addr   = 32'hBEEF_0000;
        start      = 1'b1;
        step(1);
        start = 1'b0;
        step(3);
        chk("ign_busy", 32'(busy), 32'd1);
        chk("ign_rd_cnt", 32'(tb_rd), 32'd6);
        chk("ign_rd_addr", rd_req_addr, 32'h0000_A000 + 32'(6 * CLB));
        fifo_block = 1'b0;
        wait_done(100, "done_drain");
        step(2);
        job_totals(6);

        $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
        $finish;
    end

endmodule

// File: doc/afu_job_ctrl.md
# afu_job_ctrl

Job sequencer for the complex-multiply AFU. It sits between the host memory interface and the AFU user datapath. For a job of `ctx_length` cache lines it issues line read requests from a source buffer and issues line write requests to a destination buffer as results emerge from the output FIFO. A credit counter caps the lines in flight so neither AFU FIFO can overflow, and the block reports busy/done to the control-status logic.

## Interface
- `ADDR_WIDTH`, 32: byte-address width.
- `MAX_CREDITS`, 4: maximum lines in flight (issued read, not yet write-accepted). Must be ≤ output FIFO almost-full threshold.
- `CL_BYTES`, 64: bytes per cache line, the address stride.

- `clk` in 1: clock.
- `reset` in 1: asynchronous, active-low reset.
- `start` in 1: one-cycle job launch pulse.
- `ctx_length` in 32: number of lines in the job; sampled on accepted `start`.
- `src_addr` in ADDR_WIDTH: source base; sampled on accepted `start`.
- `dst_addr` in ADDR_WIDTH: destination base; sampled on accepted `start`.
- `rd_req_valid` out 1: read request valid.
- `rd_req_ready` in 1: host accepts the read request.
- `rd_req_addr` out ADDR_WIDTH: read address.
- `wr_req_valid` out 1: write request valid.
- `wr_req_ready` in 1: host accepts the write request.
- `wr_req_addr` out ADDR_WIDTH: write address.
- `output_fifo_empty` in 1: from the AFU output FIFO.
- `output_fifo_re` out 1: pops the output FIFO.
- `busy` out 1: job in progress.
- `done` out 1: one-cycle completion pulse.

## Operation
- States:
  - IDLE: waiting for `start`.
  - RUN: reads remain to be issued.
  - DRAIN: all reads issued, writes outstanding.
  - FIN: completion cycle.
- IDLE → RUN on `start`.
- IDLE → FIN on `start` with `ctx_length==0`.
- RUN → DRAIN when the last read handshake occurs (`rd_cnt` reaches `len`).
- DRAIN → FIN on the last write handshake (`wr_cnt` reaches `len`).
- FIN → IDLE unconditionally.
- `start` outside IDLE is ignored; no registers change.
- Counters:
  - `rd_cnt` and `wr_cnt` are 32-bit and clear on accepted `start`.
  - `credits` is $clog2(MAX_CREDITS+1) bits and loads `MAX_CREDITS` on reset and on accepted `start`.
- Read issue: `rd_req_valid = (state==RUN) && credits!=0`. Handshake = `rd_req_valid && rd_req_ready`; it increments `rd_cnt` and decrements `credits`.
- Write issue: `wr_req_valid = (state==RUN||state==DRAIN) && !output_fifo_empty && wr_cnt<len`. Handshake increments `wr_cnt` and increments `credits`.
- `output_fifo_re = wr_req_valid && wr_req_ready`, i.e. exactly one pop per accepted write.
- If a read and a write handshake occur in the same cycle, `credits` is unchanged.
- Addresses:
  - `rd_req_addr = src_base + rd_cnt*CL_BYTES`; `wr_req_addr = dst_base + wr_cnt*CL_BYTES`.
  - Both are truncated to ADDR_WIDTH; wrap-around at 2^ADDR_WIDTH is silent.
  - Address outputs are registered, recomputed in the cycle after each handshake, and held stable while valid is high and ready is low.
- `busy` = state is RUN or DRAIN. `done` = state is FIN.
- Invariant: `credits + (rd_cnt - wr_cnt) == MAX_CREDITS` always. The verifier asserts it.

## Timing
- Reset (async assert, sync deassert externally) values:
  - State is IDLE.
  - All counters 0; credits = MAX_CREDITS.
  - `rd_req_valid`, `wr_req_valid`, `output_fifo_re`, `busy`, `done` are 0.
  - Address outputs are 0.
- Reset mid-job aborts immediately. Outstanding host traffic is not tracked; the FIFOs are reset by the same `reset`.
- First `rd_req_valid` rises the cycle after accepted `start`.
- `done` pulses exactly one cycle, the cycle after the last write handshake. For `ctx_length==0` it pulses 1 cycle after `start`.
- Valid never drops without a handshake, except on reset.
- Output FIFO data is presented one cycle after `output_fifo_re` (synchronous-read FIFO). The host write path captures data one cycle after the write handshake.

## Structure
- Shared package `afu_pkg`: state enum `job_state_t`, `CL_BYTES` constant, existing `complex_t`.
- Single flat module. Optional sub-module `credit_counter` (up/down saturating counter with simultaneous inc/dec) if reused by other AFUs.

## Test plan
- `ctx_length=0`, `start` → `done` high one cycle later, no `rd_req_valid`/`wr_req_valid` ever asserted.
- `ctx_length=3`, `src=0x1000`, `dst=0x8000`, ready always 1, FIFO non-empty 2 cycles after each read:
  - Read addresses are 0x1000, 0x1040, 0x1080.
  - Write addresses are 0x8000, 0x8040, 0x8080.
  - `done` pulses once.
- `ctx_length=10`, `MAX_CREDITS=4`, `output_fifo_empty` held 1 → exactly 4 reads issued, then `rd_req_valid` low. Releasing the FIFO resumes reads one per write.
- Random `rd_req_ready`/`wr_req_ready` backpressure, `ctx_length=100` → address held stable while stalled, the credit invariant never violated, exactly 100 pops.
- `src=0xFFFFFFC0`, `ctx_length=2` → read addresses 0xFFFFFFC0, then 0x00000000.
- Reset asserted mid-RUN after 5 reads; `start` during DRAIN → reset returns all outputs to reset values immediately, and `start` in DRAIN is ignored.
